// File: rtl/btn_req_latch_if.sv
// Request-latch bus: raw buttons and acknowledge controls in, sticky request
// vector and per-channel debounced status out.
interface btn_req_latch_if #(
  parameter int WIDTH = 8
) ();
  logic [WIDTH-1:0]         btn_raw;
  logic                     ack;
  logic [$clog2(WIDTH)-1:0] ack_idx;
  logic                     clr_all;
  logic [WIDTH-1:0]         sel;
  logic                     any_req;
  logic [WIDTH-1:0]         btn_level;
  logic [WIDTH-1:0]         press;

  modport master (
    output btn_raw, ack, ack_idx, clr_all,
    input  sel, any_req, btn_level, press
  );

  modport slave (
    input  btn_raw, ack, ack_idx, clr_all,
    output sel, any_req, btn_level, press
  );
endinterface

// File: rtl/btn_req_latch.sv
// Synchronises and debounces raw buttons, then holds each debounced press as a
// sticky request bit until it is acknowledged by index or cleared wholesale.
module btn_req_latch #(
  parameter int WIDTH  = 8,
  parameter int DB_CNT = 16,
  parameter int CNT_W  = 16
) (
  input logic        clk,
  input logic        rst_n,
  btn_req_latch_if.slave bus
);

  localparam int              IDX_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] s1_q;
  logic [WIDTH-1:0] s2_q;
  logic [WIDTH-1:0] lvl_q;
  logic [WIDTH-1:0] lvl_d;
  logic [WIDTH-1:0] press_q;
  logic [WIDTH-1:0] press_d;
  logic [WIDTH-1:0] sel_q;
  logic [WIDTH-1:0] sel_d;
  logic [WIDTH-1:0] set_s;
  logic [WIDTH-1:0] clr_s;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];

  // Per-channel debounce and request next-state; a set beats a clear on the same bit.
  always_comb begin
    lvl_d = lvl_q;
    set_s = {WIDTH{1'b0}};
    clr_s = {WIDTH{1'b0}};
    sel_d = sel_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = CNT_ZERO;
      clr_s[i] = bus.clr_all | (bus.ack & (bus.ack_idx == IDX_W'(i)));
      if (s2_q[i] == lvl_q[i]) begin
        cnt_d[i] = CNT_ZERO;
      end else if (cnt_q[i] == CNT_LAST) begin
        lvl_d[i] = s2_q[i];
        set_s[i] = s2_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end
      if (set_s[i]) begin
        sel_d[i] = 1'b1;
      end else if (clr_s[i]) begin
        sel_d[i] = 1'b0;
      end else begin
        sel_d[i] = sel_q[i];
      end
    end
    press_d = set_s;
  end

  // State registers; reset returns every channel to released with no requests.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= {WIDTH{1'b0}};
      s2_q    <= {WIDTH{1'b0}};
      lvl_q   <= {WIDTH{1'b0}};
      press_q <= {WIDTH{1'b0}};
      sel_q   <= {WIDTH{1'b0}};
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= CNT_ZERO;
      end
    end else begin
      s1_q    <= bus.btn_raw;
      s2_q    <= s1_q;
      lvl_q   <= lvl_d;
      press_q <= press_d;
      sel_q   <= sel_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign bus.sel       = sel_q;
  assign bus.any_req   = |sel_q;
  assign bus.btn_level = lvl_q;
  assign bus.press     = press_q;

endmodule

// File: tb/tb_btn_req_latch.sv
// Scenario bench for btn_req_latch: expected press events are queued when the
// buttons are driven and popped when the DUT reports the debounced press.
module tb_btn_req_latch;

  typedef struct {
    int         lat;
    logic [7:0] press;
    logic [7:0] sel;
    logic [7:0] lvl;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  exp_t exp_q[$];

  btn_req_latch_if #(.WIDTH(8)) bus ();

  btn_req_latch #(.WIDTH(8), .DB_CNT(16), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Ticks until press goes nonzero; lat = ticks taken, -1 on timeout.
  task automatic wait_press(input int bound, output int lat, output logic [7:0] p,
                            output logic [7:0] s, output logic [7:0] l);
    bit seen;
    seen = 1'b0;
    lat  = -1;
    p = 8'h00; s = 8'h00; l = 8'h00;
    for (int k = 1; k <= bound; k++) begin
      if (!seen) begin
        tick();
        if (bus.press !== 8'h00) begin
          seen = 1'b1;
          lat  = k;
          p = bus.press; s = bus.sel; l = bus.btn_level;
        end
      end
    end
  endtask

  task automatic test_reset();
    exp_t e;
    int lat;
    logic [7:0] p, s, l;
    int npress;
    rst_n = 1'b0;
    bus.btn_raw = 8'hFF; bus.ack = 1'b0; bus.ack_idx = 3'd0; bus.clr_all = 1'b0;
    repeat (4) tick();
    n_checks++; if (bus.sel !== 8'h00) begin n_fail++; $display("FAIL reset_sel: got %h want %h", bus.sel, 8'h00); end
    n_checks++; if (bus.btn_level !== 8'h00) begin n_fail++; $display("FAIL reset_level: got %h want %h", bus.btn_level, 8'h00); end
    n_checks++; if (bus.press !== 8'h00) begin n_fail++; $display("FAIL reset_press: got %h want %h", bus.press, 8'h00); end
    n_checks++; if (bus.any_req !== 1'b0) begin n_fail++; $display("FAIL reset_any_req: got %b want %b", bus.any_req, 1'b0); end
    exp_q.push_back('{lat: 18, press: 8'hFF, sel: 8'hFF, lvl: 8'hFF});
    rst_n = 1'b1;
    wait_press(40, lat, p, s, l);
    e = exp_q.pop_front();
    n_checks++; if (lat !== e.lat) begin n_fail++; $display("FAIL reset_held_latency: got %0d want %0d", lat, e.lat); end
    n_checks++; if (p !== e.press) begin n_fail++; $display("FAIL reset_held_press: got %h want %h", p, e.press); end
    n_checks++; if (s !== e.sel) begin n_fail++; $display("FAIL reset_held_sel: got %h want %h", s, e.sel); end
    n_checks++; if (l !== e.lvl) begin n_fail++; $display("FAIL reset_held_level: got %h want %h", l, e.lvl); end
    tick();
    n_checks++; if (bus.press !== 8'h00) begin n_fail++; $display("FAIL reset_press_one_cycle: got %h want %h", bus.press, 8'h00); end
    bus.clr_all = 1'b1; tick(); bus.clr_all = 1'b0;
    n_checks++; if (bus.sel !== 8'h00) begin n_fail++; $display("FAIL reset_clr_all: got %h want %h", bus.sel, 8'h00); end
    bus.btn_raw = 8'h00;
    npress = 0;
    repeat (20) begin tick(); if (bus.press !== 8'h00) npress++; end
    n_checks++; if (bus.btn_level !== 8'h00) begin n_fail++; $display("FAIL reset_release_level: got %h want %h", bus.btn_level, 8'h00); end
    n_checks++; if (npress !== 0) begin n_fail++; $display("FAIL reset_release_no_press: got %0d want %0d", npress, 0); end
  endtask

  task automatic test_clean_press();
    exp_t e;
    int lat;
    logic [7:0] p, s, l;
    exp_q.push_back('{lat: 18, press: 8'h08, sel: 8'h08, lvl: 8'h08});
    bus.btn_raw = 8'h08;
    wait_press(40, lat, p, s, l);
    e = exp_q.pop_front();
    n_checks++; if (lat !== e.lat) begin n_fail++; $display("FAIL press_latency: got %0d want %0d", lat, e.lat); end
    n_checks++; if (p !== e.press) begin n_fail++; $display("FAIL press_vec: got %h want %h", p, e.press); end
    n_checks++; if (s !== e.sel) begin n_fail++; $display("FAIL press_sel: got %h want %h", s, e.sel); end
    n_checks++; if (l !== e.lvl) begin n_fail++; $display("FAIL press_level: got %h want %h", l, e.lvl); end
    n_checks++; if (bus.any_req !== 1'b1) begin n_fail++; $display("FAIL press_any_req: got %b want %b", bus.any_req, 1'b1); end
    bus.btn_raw = 8'h00;
    repeat (17) tick();
    n_checks++; if (bus.btn_level !== 8'h08) begin n_fail++; $display("FAIL release_early: got %h want %h", bus.btn_level, 8'h08); end
    tick();
    n_checks++; if (bus.btn_level !== 8'h00) begin n_fail++; $display("FAIL release_level: got %h want %h", bus.btn_level, 8'h00); end
    n_checks++; if (bus.sel !== 8'h08) begin n_fail++; $display("FAIL release_keeps_sel: got %h want %h", bus.sel, 8'h08); end
  endtask

  task automatic test_bounce();
    exp_t e;
    int lat;
    logic [7:0] p, s, l;
    logic [7:0] seen;
    int extra;
    seen = 8'h00;
    bus.btn_raw = 8'h20; repeat (10) begin tick(); seen |= bus.press | bus.btn_level | (bus.sel & 8'h20); end
    bus.btn_raw = 8'h00; repeat (3)  begin tick(); seen |= bus.press | bus.btn_level | (bus.sel & 8'h20); end
    bus.btn_raw = 8'h20; repeat (10) begin tick(); seen |= bus.press | bus.btn_level | (bus.sel & 8'h20); end
    bus.btn_raw = 8'h00; repeat (20) begin tick(); seen |= bus.press | bus.btn_level | (bus.sel & 8'h20); end
    n_checks++; if (seen !== 8'h00) begin n_fail++; $display("FAIL bounce_filtered: got %h want %h", seen, 8'h00); end
    exp_q.push_back('{lat: 18, press: 8'h20, sel: 8'h28, lvl: 8'h20});
    bus.btn_raw = 8'h20;
    wait_press(40, lat, p, s, l);
    e = exp_q.pop_front();
    n_checks++; if (lat !== e.lat) begin n_fail++; $display("FAIL bounce_hold_latency: got %0d want %0d", lat, e.lat); end
    n_checks++; if (p !== e.press) begin n_fail++; $display("FAIL bounce_hold_press: got %h want %h", p, e.press); end
    n_checks++; if (s !== e.sel) begin n_fail++; $display("FAIL bounce_hold_sel: got %h want %h", s, e.sel); end
    extra = 0;
    repeat (10) begin tick(); if (bus.press !== 8'h00) extra++; end
    n_checks++; if (extra !== 0) begin n_fail++; $display("FAIL bounce_single_pulse: got %0d extra want %0d", extra, 0); end
    bus.btn_raw = 8'h00;
    repeat (20) tick();
  endtask

  task automatic test_ack();
    exp_t e;
    int lat;
    logic [7:0] p, s, l;
    bus.clr_all = 1'b1; tick(); bus.clr_all = 1'b0;
    exp_q.push_back('{lat: 18, press: 8'h14, sel: 8'h14, lvl: 8'h14});
    bus.btn_raw = 8'h14;
    wait_press(40, lat, p, s, l);
    e = exp_q.pop_front();
    n_checks++; if (lat !== e.lat) begin n_fail++; $display("FAIL ack_setup_latency: got %0d want %0d", lat, e.lat); end
    n_checks++; if (s !== e.sel) begin n_fail++; $display("FAIL ack_setup_sel: got %h want %h", s, e.sel); end
    bus.btn_raw = 8'h00;
    repeat (20) tick();
    bus.ack = 1'b1; bus.ack_idx = 3'd4; tick(); bus.ack = 1'b0;
    n_checks++; if (bus.sel !== 8'h04) begin n_fail++; $display("FAIL ack_idx4: got %h want %h", bus.sel, 8'h04); end
    bus.ack = 1'b1; bus.ack_idx = 3'd2; tick(); bus.ack = 1'b0;
    n_checks++; if (bus.sel !== 8'h00) begin n_fail++; $display("FAIL ack_idx2: got %h want %h", bus.sel, 8'h00); end
    n_checks++; if (bus.any_req !== 1'b0) begin n_fail++; $display("FAIL ack_any_req: got %b want %b", bus.any_req, 1'b0); end
    bus.ack = 1'b1; bus.ack_idx = 3'd7; tick(); bus.ack = 1'b0;
    n_checks++; if (bus.sel !== 8'h00) begin n_fail++; $display("FAIL ack_empty: got %h want %h", bus.sel, 8'h00); end
  endtask

  task automatic test_set_wins();
    exp_t e;
    exp_q.push_back('{lat: 18, press: 8'h02, sel: 8'h02, lvl: 8'h02});
    bus.btn_raw = 8'h02;
    repeat (17) tick();
    bus.ack = 1'b1; bus.ack_idx = 3'd1; tick(); bus.ack = 1'b0;
    e = exp_q.pop_front();
    n_checks++; if (bus.sel !== e.sel) begin n_fail++; $display("FAIL set_wins_sel: got %h want %h", bus.sel, e.sel); end
    n_checks++; if (bus.press !== e.press) begin n_fail++; $display("FAIL set_wins_press: got %h want %h", bus.press, e.press); end
    bus.btn_raw = 8'h00;
    repeat (20) tick();
  endtask

  task automatic test_clr_all();
    exp_t e;
    int lat;
    logic [7:0] p, s, l;
    bus.clr_all = 1'b1; tick(); bus.clr_all = 1'b0;
    exp_q.push_back('{lat: 18, press: 8'hA5, sel: 8'hA5, lvl: 8'hA5});
    bus.btn_raw = 8'hA5;
    wait_press(40, lat, p, s, l);
    e = exp_q.pop_front();
    n_checks++; if (lat !== e.lat) begin n_fail++; $display("FAIL clr_setup_latency: got %0d want %0d", lat, e.lat); end
    n_checks++; if (s !== e.sel) begin n_fail++; $display("FAIL clr_setup_sel: got %h want %h", s, e.sel); end
    bus.clr_all = 1'b1; tick(); bus.clr_all = 1'b0;
    n_checks++; if (bus.sel !== 8'h00) begin n_fail++; $display("FAIL clr_all_sel: got %h want %h", bus.sel, 8'h00); end
    exp_q.push_back('{lat: 18, press: 8'h40, sel: 8'h40, lvl: 8'hE5});
    bus.btn_raw = 8'hE5;
    repeat (17) tick();
    bus.clr_all = 1'b1; bus.ack = 1'b1; bus.ack_idx = 3'd6; tick(); bus.clr_all = 1'b0; bus.ack = 1'b0;
    e = exp_q.pop_front();
    n_checks++; if (bus.sel !== e.sel) begin n_fail++; $display("FAIL clr_all_collision_sel: got %h want %h", bus.sel, e.sel); end
    n_checks++; if (bus.press !== e.press) begin n_fail++; $display("FAIL clr_all_collision_press: got %h want %h", bus.press, e.press); end
    n_checks++; if (bus.btn_level !== e.lvl) begin n_fail++; $display("FAIL clr_all_collision_level: got %h want %h", bus.btn_level, e.lvl); end
    bus.btn_raw = 8'h00;
    repeat (20) tick();
    n_checks++; if (bus.sel !== 8'h40) begin n_fail++; $display("FAIL clr_all_release_sel: got %h want %h", bus.sel, 8'h40); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_ack();
    test_set_wins();
    test_clr_all();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
